// File: rtl/register_access_sequencer.sv
// Sequences CPU byte/word register reads and writes onto a 256x8 RAM with one-cycle read latency.
// Latency from accept edge: byte write 2, byte read 3, word write 3, word read 4 cycles.
// Backpressure: req_ready only in IDLE; no queueing, requests presented while busy wait.
module register_access_sequencer #(
  parameter int LEVEL_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_word,
  input  logic [LEVEL_BITS-1:0] req_level,
  input  logic [3:0]            req_reg,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic [LEVEL_BITS+3:0] ram_address,
  output logic                  ram_write_en,
  output logic [7:0]            ram_data_in,
  input  logic [7:0]            ram_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_HI,
    ISSUE_LO,
    CAPTURE,
    RESP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    write_q;
  logic                    word_q;
  logic [LEVEL_BITS-1:0]   level_q;
  logic [2:0]              reg_pair_q;
  logic [7:0]              wdata_lo_q;
  logic                    accept;
  logic [LEVEL_BITS+3:0]   first_address;

  assign accept = req_valid && req_ready;

  // Words pair registers on an even/odd boundary; the high byte lives at the even address.
  assign first_address = req_word ? {req_level, req_reg[3:1], 1'b0} : {req_level, req_reg};

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    ram_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) state_next = ISSUE_HI;
      end
      ISSUE_HI: begin
        ram_write_en = write_q && !reset;
        if (word_q)       state_next = ISSUE_LO;
        else if (write_q) state_next = RESP;
        else              state_next = CAPTURE;
      end
      ISSUE_LO: begin
        ram_write_en = write_q && !reset;
        state_next   = write_q ? RESP : CAPTURE;
      end
      CAPTURE: state_next = RESP;
      RESP: begin
        resp_valid = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_data_in <= '0;
      resp_rdata  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        write_q     <= req_write;
        word_q      <= req_word;
        level_q     <= req_level;
        reg_pair_q  <= req_reg[3:1];
        wdata_lo_q  <= req_wdata[7:0];
        ram_address <= first_address;
        ram_data_in <= req_word ? req_wdata[15:8] : req_wdata[7:0];
      end
      if (state == ISSUE_HI && word_q) begin
        ram_address <= {level_q, reg_pair_q, 1'b1};
        ram_data_in <= wdata_lo_q;
      end
      // RAM output here is the high byte addressed during ISSUE_HI.
      if (state == ISSUE_LO && !write_q) resp_rdata[15:8] <= ram_data_out;
      if (state == CAPTURE) begin
        resp_rdata[7:0] <= ram_data_out;
        if (!word_q) resp_rdata[15:8] <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_register_access_sequencer.sv
// Randomized and directed bench for register_access_sequencer against a RAM model and shadow memory.
module tb_register_access_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic        req_word;
  logic [3:0]  req_level;
  logic [3:0]  req_reg;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [7:0]  ram_address;
  logic        ram_write_en;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;

  logic [7:0]  ram [256];
  logic [7:0]  model_mem [256];
  logic [15:0] exp_rdata_q;
  int          checks = 0;
  int          passed = 0;
  int          double_pulses = 0;
  logic        prev_resp = 1'b0;

  always #5 clock = ~clock;

  register_access_sequencer #(.LEVEL_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_word(req_word),
    .req_level(req_level), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_address(ram_address), .ram_write_en(ram_write_en),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always @(posedge clock) begin
    if (ram_write_en) ram[ram_address] <= ram_data_in;
    ram_data_out <= ram[ram_address];
  end

  always @(negedge clock) begin
    if (resp_valid && prev_resp) double_pulses++;
    prev_resp = resp_valid;
  end

  // Reference: addresses from level*16+reg arithmetic, latency from access kind.
  task automatic model_apply(input bit wr, input bit wd, input int lvl, input int rg,
                             input logic [15:0] wdata, output int lat,
                             output logic [15:0] rdata, output logic [15:0] mask);
    int a_hi;
    a_hi = wd ? lvl * 16 + (rg / 2) * 2 : lvl * 16 + rg;
    lat  = 2 + (wd ? 1 : 0) + (wr ? 0 : 1);
    mask = 16'h0;
    if (wr) begin
      if (wd) begin
        model_mem[a_hi]     = wdata[15:8];
        model_mem[a_hi + 1] = wdata[7:0];
        mask = 16'b110;
      end else begin
        model_mem[a_hi] = wdata[7:0];
        mask = 16'b010;
      end
    end else begin
      exp_rdata_q = wd ? {model_mem[a_hi], model_mem[a_hi + 1]} : {8'h00, model_mem[a_hi]};
    end
    rdata = exp_rdata_q;
  endtask

  task automatic do_req(input bit wr, input bit wd, input logic [3:0] lvl, input logic [3:0] rg,
                        input logic [15:0] wdata, output int lat,
                        output logic [15:0] rdata, output logic [15:0] mask);
    lat = -1; mask = 16'h0; rdata = 16'hxxxx;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_word = wd;
    req_level = lvl; req_reg = rg; req_wdata = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (ram_write_en) mask[c] = 1'b1;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_level = '0; req_reg = '0; req_wdata = '0;
    repeat (3) @(negedge clock);
    checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
    checks++; if (ram_write_en !== 1'b0) $display("FAIL rst_we got %b want 0", ram_write_en); else passed++;
    checks++; if (ram_address !== 8'h00) $display("FAIL rst_addr got %h want 00", ram_address); else passed++;
    checks++; if (ram_data_in !== 8'h00) $display("FAIL rst_din got %h want 00", ram_data_in); else passed++;
    checks++; if (resp_rdata !== 16'h0000) $display("FAIL rst_rdata got %h want 0000", resp_rdata); else passed++;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after got %b want 1", req_ready); else passed++;
  endtask

  task automatic test_word_access();
    int lat, elat;
    logic [15:0] rd, erd, mask, emask;
    do_req(1'b1, 1'b1, 4'd2, 4'd4, 16'h1234, lat, rd, mask);
    model_apply(1'b1, 1'b1, 2, 4, 16'h1234, elat, erd, emask);
    checks++; if (lat !== 3) $display("FAIL ww_latency got %0d want 3", lat); else passed++;
    checks++; if (mask !== 16'b110) $display("FAIL ww_we_cycles got %b want 110", mask); else passed++;
    checks++; if (ram[8'h24] !== 8'h12) $display("FAIL ww_ram24 got %h want 12", ram[8'h24]); else passed++;
    checks++; if (ram[8'h25] !== 8'h34) $display("FAIL ww_ram25 got %h want 34", ram[8'h25]); else passed++;
    do_req(1'b0, 1'b1, 4'd2, 4'd4, 16'hFFFF, lat, rd, mask);
    model_apply(1'b0, 1'b1, 2, 4, 16'hFFFF, elat, erd, emask);
    checks++; if (lat !== 4) $display("FAIL wr_latency got %0d want 4", lat); else passed++;
    checks++; if (rd !== 16'h1234) $display("FAIL wr_rdata got %h want 1234", rd); else passed++;
    checks++; if (mask !== 16'h0) $display("FAIL wr_we_cycles got %b want 0", mask); else passed++;
  endtask

  task automatic test_byte_access();
    int lat, elat;
    logic [15:0] rd, erd, mask, emask;
    do_req(1'b0, 1'b0, 4'd2, 4'd5, 16'h0000, lat, rd, mask);
    model_apply(1'b0, 1'b0, 2, 5, 16'h0000, elat, erd, emask);
    checks++; if (lat !== 3) $display("FAIL br_latency got %0d want 3", lat); else passed++;
    checks++; if (rd !== 16'h0034) $display("FAIL br_rdata got %h want 0034", rd); else passed++;
    do_req(1'b1, 1'b0, 4'd15, 4'd15, 16'h55AB, lat, rd, mask);
    model_apply(1'b1, 1'b0, 15, 15, 16'h55AB, elat, erd, emask);
    checks++; if (lat !== 2) $display("FAIL bw_latency got %0d want 2", lat); else passed++;
    checks++; if (ram[8'hFF] !== 8'hAB) $display("FAIL bw_ramff got %h want ab", ram[8'hFF]); else passed++;
    checks++; if (rd !== 16'h0034) $display("FAIL bw_rdata_held got %h want 0034", rd); else passed++;
  endtask

  task automatic test_held_request();
    int lat, elat, accepts, acc_cycle, resps;
    logic [15:0] erd, emask;
    logic [7:0] ready_mask;
    bit drop;
    accepts = 0; acc_cycle = -1; resps = 0; ready_mask = '0; drop = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
    req_level = 4'd0; req_reg = 4'd7; req_wdata = 16'hBEEF;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    req_write = 1'b1; req_word = 1'b0; req_level = 4'd4; req_reg = 4'd3; req_wdata = 16'h0099;
    for (int c = 1; c <= 8; c++) begin
      if (req_ready) ready_mask[c - 1] = 1'b1;
      if (resp_valid) resps++;
      if (req_ready && req_valid) begin
        accepts++; acc_cycle = c; drop = 1'b1;
      end
      @(negedge clock);
      if (drop) req_valid = 1'b0;
    end
    model_apply(1'b1, 1'b1, 0, 7, 16'hBEEF, elat, erd, emask);
    model_apply(1'b1, 1'b0, 4, 3, 16'h0099, elat, erd, emask);
    lat = acc_cycle;
    checks++; if (accepts !== 1) $display("FAIL held_accepts got %0d want 1", accepts); else passed++;
    checks++; if (lat !== 4) $display("FAIL held_accept_cycle got %0d want 4", lat); else passed++;
    checks++; if (ready_mask[3:0] !== 4'b1000) $display("FAIL held_ready got %b want 1000", ready_mask[3:0]); else passed++;
    checks++; if (resps !== 2) $display("FAIL held_resps got %0d want 2", resps); else passed++;
    checks++; if (ram[8'h06] !== 8'hBE) $display("FAIL held_ram06 got %h want be", ram[8'h06]); else passed++;
    checks++; if (ram[8'h07] !== 8'hEF) $display("FAIL held_ram07 got %h want ef", ram[8'h07]); else passed++;
    checks++; if (ram[8'h43] !== 8'h99) $display("FAIL held_ram43 got %h want 99", ram[8'h43]); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat, elat, resps;
    logic [15:0] rd, erd, mask, emask;
    resps = 0;
    do_req(1'b1, 1'b1, 4'd1, 4'd0, 16'h0000, lat, rd, mask);
    model_apply(1'b1, 1'b1, 1, 0, 16'h0000, elat, erd, emask);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
    req_level = 4'd1; req_reg = 4'd0; req_wdata = 16'h5566;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    if (resp_valid) resps++;
    checks++; if (ram_write_en !== 1'b0) $display("FAIL abort_we got %b want 0", ram_write_en); else passed++;
    checks++; if (ram_address !== 8'h00) $display("FAIL abort_addr got %h want 00", ram_address); else passed++;
    checks++; if (ram_data_in !== 8'h00) $display("FAIL abort_din got %h want 00", ram_data_in); else passed++;
    checks++; if (resp_rdata !== 16'h0000) $display("FAIL abort_rdata got %h want 0000", resp_rdata); else passed++;
    reset = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", req_ready); else passed++;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) resps++;
      @(negedge clock);
    end
    model_mem[8'h10] = 8'h55;
    exp_rdata_q = 16'h0000;
    checks++; if (resps !== 0) $display("FAIL abort_resp got %0d want 0", resps); else passed++;
    checks++; if (ram[8'h10] !== 8'h55) $display("FAIL abort_ram10 got %h want 55", ram[8'h10]); else passed++;
    checks++; if (ram[8'h11] !== 8'h00) $display("FAIL abort_ram11 got %h want 00", ram[8'h11]); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, elat;
    logic [15:0] rd, erd, mask, emask;
    do_req(1'b1, 1'b0, 4'd3, 4'd9, 16'h007E, lat, rd, mask);
    model_apply(1'b1, 1'b0, 3, 9, 16'h007E, elat, erd, emask);
    do_req(1'b0, 1'b0, 4'd3, 4'd9, 16'h0000, lat, rd, mask);
    model_apply(1'b0, 1'b0, 3, 9, 16'h0000, elat, erd, emask);
    checks++; if (rd !== 16'h007E) $display("FAIL b2b_rdata got %h want 007e", rd); else passed++;
    checks++; if (lat !== 3) $display("FAIL b2b_latency got %0d want 3", lat); else passed++;
  endtask

  task automatic test_random();
    int lat, elat, mism;
    logic [15:0] rd, erd, mask, emask, wdata;
    bit wr, wd;
    logic [3:0] lvl, rg;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1)); wd = 1'($urandom_range(0, 1));
      lvl = 4'($urandom_range(0, 15)); rg = 4'($urandom_range(0, 15));
      wdata = 16'($urandom);
      do_req(wr, wd, lvl, rg, wdata, lat, rd, mask);
      model_apply(wr, wd, int'(lvl), int'(rg), wdata, elat, erd, emask);
      checks++; if (lat !== elat) $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, elat); else passed++;
      checks++; if (rd !== erd) $display("FAIL rnd_rdata[%0d] got %h want %h", n, rd, erd); else passed++;
      checks++; if (mask !== emask) $display("FAIL rnd_we[%0d] got %b want %b", n, mask, emask); else passed++;
    end
    mism = 0;
    for (int a = 0; a < 256; a++) if (ram[a] !== model_mem[a]) mism++;
    checks++; if (mism !== 0) $display("FAIL rnd_ram_image got %0d differing bytes want 0", mism); else passed++;
    checks++; if (double_pulses !== 0) $display("FAIL resp_single_pulse got %0d double pulses want 0", double_pulses); else passed++;
  endtask

  initial begin
    exp_rdata_q = 16'h0000;
    for (int a = 0; a < 256; a++) begin
      ram[a] = 8'($urandom);
      model_mem[a] = ram[a];
    end
    test_reset();
    test_word_access();
    test_byte_access();
    test_held_request();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/register_access_sequencer.md
Name: register_access_sequencer

Overview:
- Sits directly upstream of the 256x8 register RAM (D13/D14) and is the only block that drives its address, write enable and write data.
- Turns CPU register requests into one or two byte-wide RAM cycles: byte or 16-bit word, read or write, addressed by interrupt level and register index.
- Absorbs the RAM's one-cycle registered read latency.
- Returns a one-cycle response pulse carrying the assembled read data.

Parameters:
- LEVEL_BITS, 4, width of the interrupt-level field; the RAM address is {level, reg}, so LEVEL_BITS + 4 = 8.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_word  in  1  1 = 16-bit word access, 0 = byte access
- req_level  in  LEVEL_BITS  interrupt level (register bank)
- req_reg  in  4  register index within the bank
- req_wdata  in  16  write data; byte writes use [7:0]
- resp_valid  out  1  one-cycle completion pulse (reads and writes)
- resp_rdata  out  16  read result; zero-extended for byte reads
- ram_address  out  8  to RAM address
- ram_write_en  out  1  to RAM write_en
- ram_data_in  out  8  to RAM data_in
- ram_data_out  in  8  from RAM data_out, valid one cycle after the address is presented

Behaviour:
- Interface rule (decided): one clock, `clock`; reset `reset` is synchronous and active-high.
- States: IDLE, ISSUE_HI, ISSUE_LO, CAPTURE, RESP.
- req_ready = 1 only in IDLE and only while reset = 0.
- Accept: req_valid && req_ready at a rising edge. On accept, latch write, word, level, reg and wdata.
  - req_valid outside IDLE is ignored; no queueing.
- Address forming:
  - Word: hi = {level, reg[3:1], 0}, lo = {level, reg[3:1], 1}; reg[0] is ignored. The high byte is stored at the even address.
  - Byte: address = {level, reg}.
- ISSUE_HI:
  - ram_address = hi (word) or byte address.
  - Write: ram_write_en = 1; ram_data_in = wdata[15:8] (word) or wdata[7:0] (byte).
  - Next state: word -> ISSUE_LO; byte read -> CAPTURE; byte write -> RESP.
- ISSUE_LO (word only):
  - ram_address = lo.
  - Write: ram_write_en = 1; ram_data_in = wdata[7:0].
  - Read: at the end of this cycle, capture ram_data_out into resp_rdata[15:8].
  - Next state: read -> CAPTURE; write -> RESP.
- CAPTURE (reads only):
  - Capture ram_data_out into resp_rdata[7:0].
  - Byte reads also clear resp_rdata[15:8].
  - ram_write_en = 0. Next state: RESP.
- RESP: resp_valid = 1 for exactly one cycle; next state IDLE.
- Outputs in IDLE, CAPTURE and RESP: ram_write_en = 0; ram_address holds its last value.
- Latency, counting the accept edge as cycle 0, resp_valid is high in:
  - byte write: cycle 2
  - byte read: cycle 3
  - word write: cycle 3
  - word read: cycle 4
- Minimum spacing between accepts: the response cycle plus one IDLE cycle.
- resp_rdata:
  - Holds its value until the next read updates it.
  - Writes do not change it.
  - It is not valid while a read is in progress.
- Read after write: a read accepted after a write's resp_valid returns the new data, with no forwarding logic.
- Reset:
  - Next state IDLE; resp_valid = 0; resp_rdata = 0; ram_address = 0; ram_data_in = 0.
  - ram_write_en is gated combinationally by !reset, so no RAM write occurs on any edge where reset = 1.
  - Reset between ISSUE_HI and ISSUE_LO of a word write leaves the high byte written and the low byte untouched. This partial write is acceptable; no rollback.
  - No resp_valid is produced for an aborted request.
  - req_ready = 1 in the first cycle after reset deasserts.
- Arithmetic: no carry across levels; reg[3:1] = 7 maps to addresses {level, 1110} and {level, 1111}.

Test Plan:
- Word write, level 2, reg 4, data 0x1234 -> RAM[0x24] = 0x12 and RAM[0x25] = 0x34; ram_write_en high in cycles 1 and 2 only; resp_valid in cycle 3.
- Word read, level 2, reg 4 after that write -> resp_valid in cycle 4 with resp_rdata = 0x1234; ram_write_en never asserted.
- Byte read, level 2, reg 5 -> resp_valid in cycle 3 with resp_rdata = 0x0034. Byte write 0xAB to level 15, reg 15 -> RAM[0xFF] = 0xAB; resp_valid in cycle 2.
- Word write 0xBEEF to level 0, reg 7 (odd) -> RAM[0x06] = 0xBE and RAM[0x07] = 0xEF. Keep req_valid high with new data throughout the request -> no second accept until IDLE; the held request is accepted exactly once, in the IDLE cycle after RESP.
- Word write 0x5566 to level 1, reg 0 over a prior 0x0000, with reset asserted in the ISSUE_LO cycle -> RAM[0x10] = 0x55, RAM[0x11] = 0x00; no resp_valid; all outputs at their reset values; req_ready = 1 the cycle after reset drops.
- Back-to-back byte write 0x7E then byte read of level 3, reg 9 -> read returns 0x007E. resp_valid is never high for more than one consecutive cycle.
